mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Single-port memory access sequencer: word/half/byte loads, and stores (sub-word stores do read-modify-write).
// Latency: load MEM_LAT+1, word store 2, sub-word store MEM_LAT+2 cycles to done; req is ignored while busy.
module mem_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        req_full;
    logic        read_last;
    logic [31:0] load_val;

    assign req_full  = (size == 2'b00) || (size == 2'b11);
    assign read_last = (state == READ) && (cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = (we && req_full) ? WRITE : READ;
                end
            end
            READ: begin
                if (cnt == 4'd0) begin
                    state_nxt = we_q ? WRITE : DONE;
                end
            end
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load extraction takes the top bytes of the word returned by memory.
    always_comb begin
        load_val = mem_dout;
        case (size_q)
            2'b01:   load_val = {16'b0, mem_dout[31:16]};
            2'b10:   load_val = {24'b0, mem_dout[31:24]};
            default: load_val = mem_dout;
        endcase
    end

    always_comb begin
        mem_din = wdata_q;
        case (size_q)
            2'b01:   mem_din = {wdata_q[15:0], word_q[15:0]};
            2'b10:   mem_din = {wdata_q[7:0], word_q[23:0]};
            default: mem_din = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= 4'(MEM_LAT - 1);
            end
            if (state == READ && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (read_last) begin
                word_q <= mem_dout;
                if (!we_q) begin
                    rdata <= load_val;
                end
            end
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign mem_wr   = (state == WRITE);
    assign mem_addr = addr_q;

endmodule
